stack_ctrl: RTL

- Sequencer that drives the stack pointer and data-memory side of PUSH/POP/CALL/RET.
- Reads the current SP (register R3) from the register file.
- Generates the SP update, data-memory read/write strobes and the register writeback for POP.
- Generates the PC reload for RET.
- Sits between decode/execute and the register file / data memory, and stalls the pipeline while busy.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/stack_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack op codes, stack sequencer state encoding and
// datapath defaults (data width, reset value of the stack pointer R3).
package cpu_pkg;

  localparam int unsigned DW_DEF     = 32'd8;
  localparam logic [7:0]  SP_RST_DEF = 8'hFF;

  localparam logic [1:0] STK_PUSH = 2'b00;
  localparam logic [1:0] STK_POP  = 2'b01;
  localparam logic [1:0] STK_CALL = 2'b10;
  localparam logic [1:0] STK_RET  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4
  } stk_state_e;

  // PUSH and CALL store to the stack; POP and RET load from it.
  function automatic logic is_write_op(input logic [1:0] code);
    return (code == STK_PUSH) || (code == STK_CALL);
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer for PUSH/POP/CALL/RET: SP update, data-memory strobes, POP
// writeback and RET PC reload. Define STACK_GUARD_EN for overflow/underflow squashing.
module stack_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
`ifdef STACK_GUARD_EN
  ,
  parameter logic [DW-1:0] SP_RST = DW'(SP_RST_DEF)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    op_code,
  input  logic [1:0]    op_dest,
  input  logic [DW-1:0] op_data,
  input  logic [DW-1:0] sp_in,
  output logic          sp_wr_en,
  output logic [DW-1:0] sp_next,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_wr_en,
  output logic [1:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          pc_load,
  output logic [DW-1:0] pc_value,
  output logic          busy,
`ifdef STACK_GUARD_EN
  output logic          stack_fault,
`endif
  output logic          done
);

  typedef struct packed {
    logic          sp_wr_en;
    logic [DW-1:0] sp_next;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic          rf_wr_en;
    logic [1:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pc_load;
    logic [DW-1:0] pc_value;
    logic          done;
    logic          busy;
    logic          op_ready;
  } out_t;

  localparam int unsigned   OW      = $bits(out_t);
  localparam out_t          OUT_RST = out_t'({{(OW-1){1'b0}}, 1'b1});
  localparam logic [DW-1:0] SP_ONE  = DW'(1'b1);

  stk_state_e state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [1:0] dest_q, dest_d;
  out_t       out_q, out_d;
  logic       accept_s;
  logic       fault_s;

  assign accept_s = op_valid && out_q.op_ready;

`ifdef STACK_GUARD_EN
  logic fault_q;

  assign fault_s = is_write_op(op_code) ? (sp_in == {DW{1'b0}}) : (sp_in == SP_RST);

  // Sticky fault flag, only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (accept_s && fault_s) begin
      fault_q <= 1'b1;
    end
  end

  assign stack_fault = fault_q;
`else
  assign fault_s = 1'b0;
`endif

  // Next state plus next registered outputs; outputs are built for the state being entered
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dest_d  = dest_q;
    out_d   = out_t'({OW{1'b0}});
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          code_d = op_code;
          dest_d = op_dest;
          if (fault_s) begin
            // squashed op: stay idle, only the completion pulse
            state_d    = ST_IDLE;
            out_d.done = 1'b1;
          end else if (is_write_op(op_code)) begin
            state_d         = ST_WRITE;
            out_d.mem_we    = 1'b1;
            out_d.mem_addr  = sp_in;
            out_d.mem_wdata = op_data;
            out_d.sp_wr_en  = 1'b1;
            out_d.sp_next   = sp_in - SP_ONE;
            out_d.done      = 1'b1;
          end else begin
            state_d        = ST_READ;
            out_d.mem_re   = 1'b1;
            out_d.mem_addr = sp_in + SP_ONE;
            out_d.sp_wr_en = 1'b1;
            out_d.sp_next  = sp_in + SP_ONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT: begin
        // memory data is valid this cycle; it lands in the WB-cycle outputs
        state_d    = ST_WB;
        out_d.done = 1'b1;
        if (code_q == STK_RET) begin
          out_d.pc_load  = 1'b1;
          out_d.pc_value = mem_rdata;
        end else begin
          out_d.rf_wr_en = 1'b1;
          out_d.rf_waddr = dest_q;
          out_d.rf_wdata = mem_rdata;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    out_d.op_ready = (state_d == ST_IDLE);
    out_d.busy     = (state_d != ST_IDLE);
  end

  // State, latched op fields and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= STK_PUSH;
      dest_q  <= 2'b00;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dest_q  <= dest_d;
      out_q   <= out_d;
    end
  end

  assign op_ready  = out_q.op_ready;
  assign busy      = out_q.busy;
  assign done      = out_q.done;
  assign sp_wr_en  = out_q.sp_wr_en;
  assign sp_next   = out_q.sp_next;
  assign mem_addr  = out_q.mem_addr;
  assign mem_wdata = out_q.mem_wdata;
  assign mem_we    = out_q.mem_we;
  assign mem_re    = out_q.mem_re;
  assign rf_wr_en  = out_q.rf_wr_en;
  assign rf_waddr  = out_q.rf_waddr;
  assign rf_wdata  = out_q.rf_wdata;
  assign pc_load   = out_q.pc_load;
  assign pc_value  = out_q.pc_value;

endmodule
